// File: rtl/mips_greg_bank.sv
// mips_greg_bank: general-purpose register bank with two combinational
// read ports, one write port, a per-register pending-write scoreboard and
// a sequential clear engine that zeroes one register per cycle.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width (2**ADDR_W registers)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes/pend sets
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   rd_addr_1/2                read addresses
//   rd_data_1/2, rd_pend_1/2   read data and pending bit per port
//   wr_en, wr_addr, wr_data    write port (ignored while clearing)
//   pend_set, pend_addr        mark a register as awaiting a write
//   clr_req                    start a full-bank clear
//   clr_busy                   clear sequence in progress
//
// Optional feature macro: GREG_BYPASS_EN
//   Defined: a write in flight is forwarded to any read port addressing the
//   same register in the same cycle (data = wr_data, pending = 0).
//   Undefined: reads see stored contents only.

module mips_greg_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_pend_1,
    output logic              rd_pend_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int unsigned NREG = 2**ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic              wr_ok;
    logic              pend_ok;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign clr_busy = (state == CLEAR);

    // Writes and pend sets are dropped while clearing and, with a hardwired
    // zero register, when they target register 0.
    assign wr_ok   = wr_en    && !clr_busy && !is_zero_reg(wr_addr);
    assign pend_ok = pend_set && !clr_busy && !is_zero_reg(pend_addr);

    // ---------------- clear FSM ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req)         state_next = CLEAR;
            CLEAR:   if (clr_idx == '1)   state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // The index wraps to 0 on the final clear edge, ready for the next run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ---------------- scoreboard ----------------
    // The set is applied after the write-clear so a same-edge set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (state == CLEAR) begin
            pend[clr_idx] <= 1'b0;
        end else begin
            if (wr_ok)
                pend[wr_addr] <= 1'b0;
            if (pend_ok)
                pend[pend_addr] <= 1'b1;
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        rd_pend_1 = pend[rd_addr_1];
        if (is_zero_reg(rd_addr_1)) begin
            rd_data_1 = '0;
            rd_pend_1 = 1'b0;
        end
`ifdef GREG_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_1)) begin
            rd_data_1 = wr_data;
            rd_pend_1 = 1'b0;
        end
`endif
    end

    always_comb begin
        rd_data_2 = regs[rd_addr_2];
        rd_pend_2 = pend[rd_addr_2];
        if (is_zero_reg(rd_addr_2)) begin
            rd_data_2 = '0;
            rd_pend_2 = 1'b0;
        end
`ifdef GREG_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_2)) begin
            rd_data_2 = wr_data;
            rd_pend_2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_mips_greg_bank.sv
// Self-checking bench for mips_greg_bank: a default instance (32x32,
// hardwired r0) and a wide instance (16x64, r0 ordinary storage).

module tb_mips_greg_bank;

    logic        clk = 1'b0;
    logic        rst;

    // default-configuration instance
    logic [4:0]  rd_addr_1, rd_addr_2, wr_addr, pend_addr;
    logic [31:0] rd_data_1, rd_data_2, wr_data;
    logic        rd_pend_1, rd_pend_2, wr_en, pend_set, clr_req, clr_busy;

    // wide instance
    logic [3:0]  w_rd_addr_1, w_rd_addr_2, w_wr_addr, w_pend_addr;
    logic [63:0] w_rd_data_1, w_rd_data_2, w_wr_data;
    logic        w_rd_pend_1, w_rd_pend_2, w_wr_en, w_pend_set, w_clr_req, w_clr_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_greg_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_pend_1(rd_pend_1), .rd_pend_2(rd_pend_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    mips_greg_bank #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(0)) dut_w (
        .clk(clk), .rst(rst),
        .rd_addr_1(w_rd_addr_1), .rd_addr_2(w_rd_addr_2),
        .rd_data_1(w_rd_data_1), .rd_data_2(w_rd_data_2),
        .rd_pend_1(w_rd_pend_1), .rd_pend_2(w_rd_pend_2),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .pend_set(w_pend_set), .pend_addr(w_pend_addr),
        .clr_req(w_clr_req), .clr_busy(w_clr_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_addr_1 = 5'd3; rd_addr_2 = 5'd31;
        #3;
        checks++;
        if (rd_data_1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h expected %h", rd_data_1, 32'h0); end
        checks++;
        if (rd_pend_2 !== 1'b0) begin errors++; $display("FAIL reset_pend2: got %b expected 0", rd_pend_2); end
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
        checks++;
        if (w_clr_busy !== 1'b0) begin errors++; $display("FAIL reset_w_busy: got %b expected 0", w_clr_busy); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
        tick();
        wr_en = 1'b0;
        rd_addr_1 = 5'd3; rd_addr_2 = 5'd3;
        #1;
        checks++;
        if (rd_data_1 !== 32'h12345678) begin errors++; $display("FAIL wr_rd_reg3_p1: got %h expected %h", rd_data_1, 32'h12345678); end
        checks++;
        if (rd_data_2 !== 32'h12345678) begin errors++; $display("FAIL wr_rd_reg3_p2: got %h expected %h", rd_data_2, 32'h12345678); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0;
        rd_addr_1 = 5'd0;
        #1;
        checks++;
        if (rd_data_1 !== 32'h0) begin errors++; $display("FAIL wr_rd_reg0: got %h expected %h", rd_data_1, 32'h0); end
    endtask

    task automatic test_scoreboard;
        pend_set = 1'b1; pend_addr = 5'd7;
        tick();
        pend_set = 1'b0;
        rd_addr_1 = 5'd7; rd_addr_2 = 5'd6;
        #1;
        checks++;
        if (rd_pend_1 !== 1'b1) begin errors++; $display("FAIL pend_set7: got %b expected 1", rd_pend_1); end
        checks++;
        if (rd_pend_2 !== 1'b0) begin errors++; $display("FAIL pend_other6: got %b expected 0", rd_pend_2); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h000000A5;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_pend_1 !== 1'b0) begin errors++; $display("FAIL pend_clr7: got %b expected 0", rd_pend_1); end
        checks++;
        if (rd_data_1 !== 32'hA5) begin errors++; $display("FAIL data7: got %h expected %h", rd_data_1, 32'hA5); end
        pend_set = 1'b1; pend_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000005A;
        tick();
        pend_set = 1'b0; wr_en = 1'b0;
        checks++;
        if (rd_pend_1 !== 1'b1) begin errors++; $display("FAIL pend_set_wins: got %b expected 1", rd_pend_1); end
        checks++;
        if (rd_data_1 !== 32'h5A) begin errors++; $display("FAIL data7_same_edge: got %h expected %h", rd_data_1, 32'h5A); end
        pend_set = 1'b1; pend_addr = 5'd0;
        tick();
        pend_set = 1'b0;
        rd_addr_2 = 5'd0;
        #1;
        checks++;
        if (rd_pend_2 !== 1'b0) begin errors++; $display("FAIL pend_reg0: got %b expected 0", rd_pend_2); end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_d;
        logic        exp_p;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
        tick();
        wr_en = 1'b0;
        pend_set = 1'b1; pend_addr = 5'd5;
        tick();
        pend_set = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr_2 = 5'd5;
        #1;
`ifdef GREG_BYPASS_EN
        exp_d = 32'hDEADBEEF; exp_p = 1'b0;
`else
        exp_d = 32'h11111111; exp_p = 1'b1;
`endif
        checks++;
        if (rd_data_2 !== exp_d) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data_2, exp_d); end
        checks++;
        if (rd_pend_2 !== exp_p) begin errors++; $display("FAIL bypass_pend: got %b expected %b", rd_pend_2, exp_p); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_2 !== 32'hDEADBEEF) begin errors++; $display("FAIL after_write5: got %h expected %h", rd_data_2, 32'hDEADBEEF); end
        checks++;
        if (rd_pend_2 !== 1'b0) begin errors++; $display("FAIL after_write5_pend: got %b expected 0", rd_pend_2); end
    endtask

    task automatic test_clear;
        int cnt;
        logic [4:0] a;
        wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        pend_set = 1'b0;
        rd_addr_1 = 5'd31;
        #1;
        checks++;
        if (rd_data_1 !== 32'h101F) begin errors++; $display("FAIL fill_reg31: got %h expected %h", rd_data_1, 32'h101F); end
        // clear request and a write on the same idle edge: write lands
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE0000;
        tick();
        clr_req = 1'b0;
        rd_addr_1 = 5'd12;
        #1;
        checks++;
        if (rd_data_1 !== 32'hCAFE0000) begin errors++; $display("FAIL write_with_clr_req: got %h expected %h", rd_data_1, 32'hCAFE0000); end
        // keep hammering writes / pend sets that must be ignored
        wr_addr = 5'd4; wr_data = 32'hFFFF0000; pend_set = 1'b1; pend_addr = 5'd4;
        rd_addr_1 = 5'd2; rd_addr_2 = 5'd31;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                checks++;
                if (rd_data_1 !== 32'h0) begin errors++; $display("FAIL mid_clear_reg2: got %h expected %h", rd_data_1, 32'h0); end
                checks++;
                if (rd_data_2 !== 32'h101F) begin errors++; $display("FAIL mid_clear_reg31: got %h expected %h", rd_data_2, 32'h101F); end
            end
            clr_req = (cnt == 8);
            tick();
        end
        wr_en = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
        checks++;
        if (cnt !== 32) begin errors++; $display("FAIL clear_cycles: got %0d expected 32", cnt); end
        for (int i = 0; i < 32; i += 2) begin
            a = 5'(i);
            rd_addr_1 = a; rd_addr_2 = a + 5'd1;
            #1;
            checks++;
            if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
                errors++; $display("FAIL cleared_pair_%0d: got %h %h expected 0 0", i, rd_data_1, rd_data_2);
            end
            checks++;
            if (rd_pend_1 !== 1'b0 || rd_pend_2 !== 1'b0) begin
                errors++; $display("FAIL cleared_pend_%0d: got %b %b expected 0 0", i, rd_pend_1, rd_pend_2);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
        tick();
        wr_addr = 5'd25; wr_data = 32'h88;
        tick();
        wr_en = 1'b0;
        pend_set = 1'b1; pend_addr = 5'd22;
        tick();
        pend_set = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rd_addr_1 = 5'd20; rd_addr_2 = 5'd22;
        #1;
        checks++;
        if (rd_data_1 !== 32'h77 || rd_pend_2 !== 1'b1) begin
            errors++; $display("FAIL pre_abort_state: got %h %b expected %h 1", rd_data_1, rd_pend_2, 32'h77);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", clr_busy); end
        checks++;
        if (rd_data_1 !== 32'h0 || rd_pend_2 !== 1'b0) begin
            errors++; $display("FAIL abort_state: got %h %b expected 0 0", rd_data_1, rd_pend_2);
        end
        tick();
        rst = 1'b0;
        tick();
        rd_addr_2 = 5'd25;
        #1;
        checks++;
        if (rd_data_2 !== 32'h0 || clr_busy !== 1'b0) begin
            errors++; $display("FAIL post_abort: got %h %b expected 0 0", rd_data_2, clr_busy);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 32) begin errors++; $display("FAIL reclear_cycles: got %0d expected 32", cnt); end
    endtask

    task automatic test_wide;
        int cnt;
        w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 64'h0123456789ABCDEF;
        tick();
        w_wr_addr = 4'd15; w_wr_data = 64'hFEDCBA9876543210;
        tick();
        w_wr_en = 1'b0;
        w_rd_addr_1 = 4'd0; w_rd_addr_2 = 4'd15;
        #1;
        checks++;
        if (w_rd_data_1 !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_reg0: got %h expected %h", w_rd_data_1, 64'h0123456789ABCDEF); end
        checks++;
        if (w_rd_data_2 !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL wide_reg15: got %h expected %h", w_rd_data_2, 64'hFEDCBA9876543210); end
        w_pend_set = 1'b1; w_pend_addr = 4'd0;
        tick();
        w_pend_set = 1'b0;
        checks++;
        if (w_rd_pend_1 !== 1'b1) begin errors++; $display("FAIL wide_pend0: got %b expected 1", w_rd_pend_1); end
        w_clr_req = 1'b1;
        tick();
        w_clr_req = 1'b0;
        cnt = 0;
        while (w_clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL wide_clear_cycles: got %0d expected 16", cnt); end
        checks++;
        if (w_rd_data_1 !== 64'h0 || w_rd_data_2 !== 64'h0 || w_rd_pend_1 !== 1'b0) begin
            errors++; $display("FAIL wide_cleared: got %h %h %b expected 0 0 0", w_rd_data_1, w_rd_data_2, w_rd_pend_1);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_1 = '0; rd_addr_2 = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0;
        w_rd_addr_1 = '0; w_rd_addr_2 = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_pend_set = 1'b0; w_pend_addr = '0; w_clr_req = 1'b0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
